// File: rtl/gray_rx_monitor.sv
// gray_rx_monitor: registers Gray samples, converts them to binary and checks that
// each valid sample is a +1 step or a hold, reporting lock, errors and wrap.
module gray_rx_monitor #(
    parameter int W      = 8,
    parameter int CW     = 4,
    parameter int LOCK_N = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [W-1:0]  gray_in,
    input  logic          clr_err,
    output logic [W-1:0]  bin_out,
    output logic          bin_valid,
    output logic          step_err,
    output logic          wrap,
    output logic          locked,
    output logic [CW-1:0] err_cnt
);
    localparam int GW = $clog2(LOCK_N + 1);

    typedef enum logic {ACQUIRE, TRACK} state_t;

    state_t        state, state_n;
    logic [W-1:0]  g_q, nb;
    logic          v_q, step_n, wrap_n, lock_n;
    logic [GW-1:0] good_cnt, good_n;
    logic [CW-1:0] err_n;

    for (genvar i = 0; i < W; i++) begin : g2b
        assign nb[i] = ^g_q[W-1:i];
    end

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        lock_n  = locked;
        step_n  = 1'b0;
        wrap_n  = 1'b0;
        if (v_q) begin
            if (state == ACQUIRE) begin
                state_n = TRACK;
                good_n  = '0;
            end else if (nb == bin_out + W'(1)) begin
                good_n = (good_cnt == GW'(LOCK_N)) ? good_cnt : good_cnt + GW'(1);
                lock_n = locked | (good_n == GW'(LOCK_N));
                wrap_n = &bin_out;
            end else if (nb != bin_out) begin
                step_n = 1'b1;
                lock_n = 1'b0;
                good_n = '0;
            end
        end
        // a clear coinciding with a new error keeps that error counted
        err_n = clr_err ? CW'(step_n) : (step_n && !(&err_cnt)) ? err_cnt + CW'(1) : err_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACQUIRE;
            g_q       <= '0;
            v_q       <= 1'b0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_err  <= 1'b0;
            wrap      <= 1'b0;
            locked    <= 1'b0;
            err_cnt   <= '0;
            good_cnt  <= '0;
        end else begin
            state     <= state_n;
            v_q       <= en;
            g_q       <= en ? gray_in : g_q;
            bin_out   <= v_q ? nb : bin_out;
            bin_valid <= v_q;
            step_err  <= step_n;
            wrap      <= wrap_n;
            locked    <= lock_n;
            err_cnt   <= err_n;
            good_cnt  <= good_n;
        end
    end
endmodule

// File: tb/tb_gray_rx_monitor.sv
// tb_gray_rx_monitor: directed table plus hand-written sequences for gray_rx_monitor.
module tb_gray_rx_monitor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] gray_in = 8'h00;
    logic       clr_err = 1'b0;
    logic [7:0] bin_out;
    logic       bin_valid, step_err, wrap, locked;
    logic [3:0] err_cnt;

    int tests = 0;
    int fails = 0;

    gray_rx_monitor #(.W(8), .CW(4), .LOCK_N(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .gray_in(gray_in), .clr_err(clr_err),
        .bin_out(bin_out), .bin_valid(bin_valid), .step_err(step_err),
        .wrap(wrap), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] gray;
        logic       clr;
        logic [7:0] bin;
        logic       bv, se, wr, lk;
        logic [3:0] ec;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic e, input logic [7:0] g, input logic c,
                                input logic [7:0] b, input logic bv, input logic se,
                                input logic wr, input logic lk, input logic [3:0] ec);
        vec_t v;
        v.en = e; v.gray = g; v.clr = c; v.bin = b;
        v.bv = bv; v.se = se; v.wr = wr; v.lk = lk; v.ec = ec;
        return v;
    endfunction

    function automatic logic [7:0] g8(input int b);
        logic [7:0] x;
        x = 8'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic cmp(input string n, input logic [7:0] a, input logic [7:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", n, a, e);
        end
    endtask

    task automatic check_out(input string t, input logic [7:0] b, input logic bv,
                             input logic se, input logic wr, input logic lk, input logic [3:0] ec);
        cmp({t, ".bin_out"},   bin_out, b);
        cmp({t, ".bin_valid"}, 8'(bin_valid), 8'(bv));
        cmp({t, ".step_err"},  8'(step_err), 8'(se));
        cmp({t, ".wrap"},      8'(wrap), 8'(wr));
        cmp({t, ".locked"},    8'(locked), 8'(lk));
        cmp({t, ".err_cnt"},   8'(err_cnt), 8'(ec));
    endtask

    task automatic step(input logic e, input logic [7:0] g, input logic c);
        @(negedge clk);
        en = e; gray_in = g; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int wraps;
        // outputs after row k reflect the sample driven in row k-1
        tbl[0]  = mk(1'b1, 8'h00, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tbl[1]  = mk(1'b1, 8'h01, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tbl[2]  = mk(1'b1, 8'h03, 1'b0, 8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tbl[3]  = mk(1'b1, 8'h02, 1'b0, 8'd2,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tbl[4]  = mk(1'b1, 8'h06, 1'b0, 8'd3,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tbl[5]  = mk(1'b1, 8'h07, 1'b0, 8'd4,  1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        tbl[6]  = mk(1'b1, 8'h07, 1'b0, 8'd5,  1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        tbl[7]  = mk(1'b1, 8'h0C, 1'b0, 8'd5,  1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        tbl[8]  = mk(1'b1, 8'h0D, 1'b0, 8'd8,  1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        tbl[9]  = mk(1'b0, 8'h0D, 1'b0, 8'd9,  1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[10] = mk(1'b0, 8'h0D, 1'b0, 8'd9,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[11] = mk(1'b0, 8'h0D, 1'b0, 8'd9,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[12] = mk(1'b1, 8'h0F, 1'b0, 8'd9,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[13] = mk(1'b1, 8'h0E, 1'b0, 8'd10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[14] = mk(1'b1, 8'h0A, 1'b0, 8'd11, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[15] = mk(1'b1, 8'h0B, 1'b0, 8'd12, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        tbl[16] = mk(1'b1, 8'h0B, 1'b1, 8'd13, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        tbl[17] = mk(1'b1, 8'h0B, 1'b0, 8'd13, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);

        #1;
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 18; k++) begin
            step(tbl[k].en, tbl[k].gray, tbl[k].clr);
            check_out($sformatf("row%0d", k), tbl[k].bin, tbl[k].bv, tbl[k].se,
                      tbl[k].wr, tbl[k].lk, tbl[k].ec);
        end

        // full 256-count run through the all-ones to zero wrap
        do_reset();
        wraps = 0;
        for (int i = 0; i <= 260; i++) begin
            step(1'b1, g8(i), 1'b0);
            if (wrap === 1'b1) wraps++;
            if (i >= 1 && (i == 1 || i >= 254))
                check_out($sformatf("run%0d", i), 8'(i - 1), 1'b1, 1'b0,
                          1'b0 | ((i - 1) == 256), (i - 1) >= 4, 4'd0);
            else if (i >= 1) begin
                cmp($sformatf("run%0d.bin_out", i), bin_out, 8'(i - 1));
                cmp($sformatf("run%0d.step_err", i), 8'(step_err), 8'h00);
            end
        end
        cmp("wrap_count", 8'(wraps), 8'd1);

        // en low for three cycles while locked
        step(1'b0, g8(260), 1'b0);
        check_out("gap0", 8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, g8(260), 1'b0);
        check_out("gap1", 8'd4, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, g8(260), 1'b0);
        check_out("gap2", 8'd4, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b1, g8(261), 1'b0);
        check_out("gap3", 8'd4, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b1, g8(262), 1'b0);
        check_out("resume", 8'd5, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);

        // 20 illegal jumps between 0x80 and 0x00, then a 21st with clear on its edge
        for (int i = 0; i <= 20; i++) begin
            step(1'b1, (i % 2 == 0) ? 8'hC0 : 8'h00, 1'b0);
            if (i >= 1)
                check_out($sformatf("sat%0d", i), (i % 2 == 1) ? 8'h80 : 8'h00, 1'b1,
                          1'b1, 1'b0, 1'b0, (i > 15) ? 4'd15 : 4'(i));
        end
        step(1'b1, 8'hC0, 1'b1);
        check_out("clr_with_err", 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        step(1'b1, 8'hC0, 1'b1);
        check_out("clr_alone", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // asynchronous reset mid-stream while locked at 0x37
        do_reset();
        for (int j = 8'h30; j <= 8'h38; j++) step(1'b1, g8(j), 1'b0);
        check_out("pre_rst", 8'h37, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h50, 1'b0);
        check_out("post0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, g8(8'h61), 1'b0);
        check_out("post1", 8'h60, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int j = 8'h62; j <= 8'h65; j++) step(1'b1, g8(j), 1'b0);
        check_out("post_lock", 8'h64, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
